invkeysched: RTL and testbench
==============================

# invkeysched

Round-key generator for the 128-bit AES inverse cipher. It accepts a 128-bit cipher key and expands it into the 11 round keys in 10 cycles, buffering them as it goes. It then streams the keys in reverse order, round 10 first and round 0 last, one 128-bit block per cycle. It sits directly upstream of the inverse cipher stage and supplies that stage's per-cycle key block and its `done` indication.

## Interface
- No parameters; fixed Nk=4, Nr=10 (AES-128).
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clock clk
- `start`  in  1  single-cycle request to expand `key`; sampled only in IDLE
- `key`  in  128  cipher key; `key[127:96]` = w0 … `key[31:0]` = w3; sampled on the start edge only
- `wBlock`  out  128  current round key (4 words, same packing as `key`); 0 when `valid`=0
- `valid`  out  1  high while `wBlock` carries a round key to consume
- `done`  out  1  high only in the cycle that presents round key 0
- `busy`  out  1  high in EXPAND and PLAY

## Operation
- States: IDLE, EXPAND, PLAY.
  - IDLE -> EXPAND on `start`.
  - EXPAND -> PLAY after round key 10 is stored.
  - PLAY -> IDLE after round key 0 is presented.
- Storage: 11 x 128-bit round-key registers rk[0..10].
  - Storage is not cleared by reset; contents are don't-care until rewritten.
- Start edge:
  - rk[0] <= `key`.
  - Working key register <= `key`.
  - Round counter r <= 1.
- EXPAND, each edge:
  - With previous round key words p0..p3: t = SubWord(RotWord(p3)) ^ {rcon[r], 24'h0}.
  - n0 = p0^t, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2.
  - rk[r] <= {n0,n1,n2,n3}; working key <= same value; r <= r+1.
  - After r=10 is written, go to PLAY with play index i <= 10.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses four instances of the team's existing forward S-box, combinational, one per byte.
- PLAY, each cycle:
  - `wBlock` = rk[i]; `valid`=1; `done` = (i==0).
  - Each edge decrements i. The edge with i==0 returns to IDLE.
- `start` in EXPAND or PLAY is ignored. There is no queuing and no abort.
- `key` changes after the start edge have no effect.
- No back-pressure: the consumer must take one block per `valid` cycle.

## Timing
- Reset values:
  - state=IDLE.
  - `wBlock`=0, `valid`=0, `done`=0, `busy`=0.
  - r=0, i=0.
- Outputs are decoded from registered state, index and storage. There is no combinational path from `start`/`key` to outputs.
- Latency, with E0 as the edge that samples `start`:
  - `busy` rises after E0.
  - EXPAND occupies the 10 cycles after E0; edges E1..E10 write rk[1..10].
  - After E10: `valid`=1 and `wBlock`=rk[10].
  - After E20: `wBlock`=rk[0] with `done`=1.
  - After E21: back in IDLE with all outputs 0.
- Throughput: 21 cycles per key, including the IDLE turnaround.
  - The earliest next start is sampled at E21, giving back-to-back operation.
- Reset mid-operation:
  - The next edge forces IDLE and clears all outputs.
  - A partial expansion is discarded.
  - `done` never fires for an aborted run.
- `reset` and `start` asserted together: reset wins; the block stays in IDLE.

## Test plan
- Reset: assert reset 2 cycles with `start`=1 -> `valid`/`done`/`busy`=0, `wBlock`=0; no transition to EXPAND.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - First `valid` cycle is 10 edges after E0, with `wBlock`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 10th `valid` cycle `wBlock`=a0fafe1788542cb123a339392a6c7605.
  - 11th cycle `wBlock`=2b7e151628aed2a6abf7158809cf4f3c with `done`=1; then `valid`=0.
- Key 000102030405060708090a0b0c0d0e0f:
  - First `valid` `wBlock`=13111d7fe3944a17f307a78b4d2b30c5.
  - Last `wBlock`=000102030405060708090a0b0c0d0e0f with `done`=1.
- Start while busy: pulse `start` with a different key during EXPAND and during PLAY -> output sequence is unchanged; exactly 11 `valid` cycles.
- Reset mid-run: reset at PLAY cycle 4 -> outputs 0 on the next cycle, no `done`. A new start then yields the full correct sequence.
- Back-to-back: second start sampled at E21 with the C.1 key -> its first key appears 10 edges later; no stale rk values appear.

Source files
------------

// File: rtl/invkeysched.sv
// AES-128 inverse-cipher key schedule: expands a cipher key into 11 round keys,
// then streams them last-round-first, one 128-bit block per cycle.

module invkeysched_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign dout = sbox_f(din);

endmodule

module invkeysched (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] wBlock,
    output logic         valid,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        PLAY   = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [3:0]     r_r, r_s;
    logic [3:0]     i_r, i_s;
    logic [127:0]   wkey_r, wkey_s;
    logic [127:0]   rk_r [0:10];
    logic           rk_we_s;
    logic [3:0]     rk_idx_s;
    logic [127:0]   rk_wdata_s;
    logic [127:0]   wblock_r, wblock_s;
    logic           valid_r, valid_s;
    logic           done_r, done_s;
    logic           busy_r, busy_s;
    logic [31:0]    rot_s, sub_s, t_s;
    logic [31:0]    n0_s, n1_s, n2_s, n3_s;
    logic [127:0]   next_rk_s;

    function automatic logic [7:0] rcon_f(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign rot_s = {wkey_r[23:0], wkey_r[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            invkeysched_sbox u_sbox (
                .din  (rot_s[8*g +: 8]),
                .dout (sub_s[8*g +: 8])
            );
        end
    endgenerate

    assign t_s       = sub_s ^ {rcon_f(r_r), 24'h000000};
    assign n0_s      = wkey_r[127:96] ^ t_s;
    assign n1_s      = wkey_r[95:64]  ^ n0_s;
    assign n2_s      = wkey_r[63:32]  ^ n1_s;
    assign n3_s      = wkey_r[31:0]   ^ n2_s;
    assign next_rk_s = {n0_s, n1_s, n2_s, n3_s};

    // Next-state, storage-write and next-output decode.
    always_comb begin
        state_s    = state_r;
        r_s        = r_r;
        i_s        = i_r;
        wkey_s     = wkey_r;
        rk_we_s    = 1'b0;
        rk_idx_s   = r_r;
        rk_wdata_s = next_rk_s;
        wblock_s   = 128'h0;
        valid_s    = 1'b0;
        done_s     = 1'b0;
        busy_s     = 1'b0;
        if (reset) begin
            state_s = IDLE;
            r_s     = 4'd0;
            i_s     = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s    = EXPAND;
                        wkey_s     = key;
                        r_s        = 4'd1;
                        rk_we_s    = 1'b1;
                        rk_idx_s   = 4'd0;
                        rk_wdata_s = key;
                        busy_s     = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                EXPAND: begin
                    rk_we_s = 1'b1;
                    wkey_s  = next_rk_s;
                    r_s     = r_r + 4'd1;
                    busy_s  = 1'b1;
                    if (r_r == 4'd10) begin
                        state_s  = PLAY;
                        i_s      = 4'd10;
                        valid_s  = 1'b1;
                        wblock_s = next_rk_s;
                    end else begin
                        state_s = EXPAND;
                    end
                end
                PLAY: begin
                    if (i_r == 4'd0) begin
                        // The final playback edge doubles as the earliest start slot.
                        if (start) begin
                            state_s    = EXPAND;
                            wkey_s     = key;
                            r_s        = 4'd1;
                            rk_we_s    = 1'b1;
                            rk_idx_s   = 4'd0;
                            rk_wdata_s = key;
                            busy_s     = 1'b1;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        i_s      = i_r - 4'd1;
                        wblock_s = rk_r[i_r - 4'd1];
                        valid_s  = 1'b1;
                        done_s   = (i_r == 4'd1);
                        busy_s   = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, counters, working key and registered outputs.
    always_ff @(posedge clk) begin
        state_r  <= state_s;
        r_r      <= r_s;
        i_r      <= i_s;
        wkey_r   <= wkey_s;
        wblock_r <= wblock_s;
        valid_r  <= valid_s;
        done_r   <= done_s;
        busy_r   <= busy_s;
    end

    // Round-key storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (rk_we_s) begin
            rk_r[rk_idx_s] <= rk_wdata_s;
        end
    end

    assign wBlock = wblock_r;
    assign valid  = valid_r;
    assign done   = done_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_invkeysched.sv
// Randomized self-checking bench for invkeysched against a table-driven
// FIPS-197 key-expansion model.

module tb_invkeysched;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] wBlock;
    logic         valid;
    logic         done;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int valid_cnt;
    int done_cnt;

    logic [127:0] model_rk [0:10];
    logic [127:0] seen     [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

    logic [2047:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    invkeysched dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .key    (key),
        .wBlock (wBlock),
        .valid  (valid),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        int idx;
        for (int b = 0; b < 4; b++) begin
            idx = int'(w[8*b +: 8]);
            o[8*b +: 8] = sbox_tab[2047 - 8*idx -: 8];
        end
        return o;
    endfunction

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge; returns at the negedge just after the sampling edge E0.
    task automatic start_key(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
    endtask

    // c counts edges since E0. mode 0: plain, 1: stray starts in EXPAND/PLAY,
    // 2: chain a new start (k2) onto the final playback edge.
    task automatic run_checks(input logic [127:0] k, input int mode, input logic [127:0] k2);
        logic       eb, ev, ed;
        logic [127:0] ew;
        expand_model(k);
        valid_cnt = 0;
        done_cnt  = 0;
        for (int c = 0; c <= 21; c++) begin
            if (c > 0) @(negedge clk);
            if (mode == 2 && c == 21) break;
            start = 1'b0;
            if (c == 0) key = rand128();
            if (c >= 10 && c <= 20) begin
                eb = 1'b1; ev = 1'b1; ed = (c == 20); ew = model_rk[20 - c];
                seen[20 - c] = wBlock;
            end else if (c == 21) begin
                eb = 1'b0; ev = 1'b0; ed = 1'b0; ew = 128'h0;
            end else begin
                eb = 1'b1; ev = 1'b0; ed = 1'b0; ew = 128'h0;
            end
            check($sformatf("ctl c=%0d", c), {125'h0, busy, valid, done}, {125'h0, eb, ev, ed});
            check($sformatf("wblock c=%0d", c), wBlock, ew);
            if (valid) valid_cnt++;
            if (done) done_cnt++;
            if (mode == 1 && (c == 4 || c == 14)) begin
                start = 1'b1;
                key   = rand128();
            end
            if (mode == 2 && c == 20) begin
                start = 1'b1;
                key   = k2;
            end
        end
        start = 1'b0;
        check("valid_count", 128'(valid_cnt), 128'd11);
        check("done_count", 128'(done_cnt), 128'd1);
    endtask

    initial begin
        logic [127:0] k;

        // Reset held with start asserted must keep the block idle.
        reset = 1'b1;
        start = 1'b1;
        key   = FIPS_KEY;
        repeat (2) @(negedge clk);
        check("reset_ctl", {125'h0, busy, valid, done}, 128'h0);
        check("reset_wblock", wBlock, 128'h0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_no_expand", {125'h0, busy, valid, done}, 128'h0);

        start_key(FIPS_KEY);
        run_checks(FIPS_KEY, 0, 128'h0);
        check("fips_rk10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_rk1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk0", seen[0], FIPS_KEY);
        @(negedge clk);

        start_key(C1_KEY);
        run_checks(C1_KEY, 0, 128'h0);
        check("c1_rk10", seen[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("c1_rk0", seen[0], C1_KEY);

        // Stray start pulses while busy.
        start_key(rand128());
        run_checks(dut.key, 1, 128'h0);
        @(negedge clk);

        // Reset during the fourth playback cycle.
        k = rand128();
        start_key(k);
        start = 1'b0;
        expand_model(k);
        repeat (13) @(negedge clk);
        check("midrun_valid", {127'h0, valid}, 128'h1);
        check("midrun_wblock", wBlock, model_rk[7]);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ctl", {125'h0, busy, valid, done}, 128'h0);
        check("abort_wblock", wBlock, 128'h0);
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || valid || busy) done_cnt++;
        end
        check("abort_quiet", 128'(done_cnt), 128'd0);
        k = rand128();
        start_key(k);
        run_checks(k, 0, 128'h0);

        // Back-to-back: second start sampled on the final playback edge.
        start_key(FIPS_KEY);
        run_checks(FIPS_KEY, 2, C1_KEY);
        run_checks(C1_KEY, 0, 128'h0);
        check("b2b_rk10", seen[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        for (int n = 0; n < 4; n++) begin
            k = rand128();
            start_key(k);
            run_checks(k, n % 2, 128'h0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
